// File: rtl/shift_reg_4_ctrl_if.sv
// Word handshake between an upstream source and the shift_reg_4_ctrl serializer.
// The source drives din/dir/din_valid; the controller answers with din_ready.
interface shift_reg_4_ctrl_if;
  logic [3:0] din;
  logic       din_valid;
  logic       din_ready;
  logic       dir;

  modport master (output din, din_valid, dir, input din_ready);
  modport slave  (input din, din_valid, dir, output din_ready);
endinterface

// File: rtl/shift_reg_4_ctrl.sv
// Sequencer for a 4-bit universal shift register: loads a word, paces four shifts
// and serializes it LSB- or MSB-first. Optional abort: define SHIFT_REG_4_CTRL_ABORT_EN.
module shift_reg_4_ctrl #(
  parameter int unsigned BIT_DIV = 4,
  parameter int unsigned CNT_W   = 8
) (
  input  logic              CLK,
  input  logic              Clear_b,
  shift_reg_4_ctrl_if.slave word,
  input  logic [3:0]        A_par,
  output logic              s1,
  output logic              s0,
  output logic [3:0]        I_par,
  output logic              MSB_in,
  output logic              LSB_in,
  output logic              ser_out,
  output logic              bit_strobe,
  output logic              busy,
  output logic              done
`ifdef SHIFT_REG_4_CTRL_ABORT_EN
  ,
  input  logic              abort,
  output logic              aborted
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_HOLD,
    S_SHIFT,
    S_DONE
`ifdef SHIFT_REG_4_CTRL_ABORT_EN
    ,
    S_ABORT
`endif
  } state_t;

  // With a one-cycle bit period there are no HOLD cycles: SHIFT repeats back to back.
  localparam bit                DIV1       = (BIT_DIV == 1);
  localparam int unsigned       PER_LAST_I = (BIT_DIV >= 2) ? BIT_DIV - 2 : 0;
  localparam logic [CNT_W-1:0]  PER_LAST   = CNT_W'(PER_LAST_I);

  state_t           state, state_nx;
  logic [3:0]       i_par_q;
  logic             dir_q;
  logic [1:0]       bit_cnt;
  logic [CNT_W-1:0] per_cnt;
  logic             ready_en;
  logic             accept;
  logic [1:0]       mode;
  logic             unused;

  // Only the two end bits of the register ever reach the serial line.
  assign unused = ^A_par[2:1];

  // din_ready waits for one clean edge out of reset before advertising IDLE.
  assign word.din_ready = (state == S_IDLE) && ready_en;
  assign accept         = word.din_ready && word.din_valid;

  assign MSB_in  = 1'b1;
  assign LSB_in  = 1'b1;
  assign {s1, s0} = mode;
  assign ser_out = busy ? (dir_q ? A_par[3] : A_par[0]) : 1'b1;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (!Clear_b) begin
      state    <= S_IDLE;
      i_par_q  <= 4'h0;
      dir_q    <= 1'b0;
      bit_cnt  <= 2'd0;
      per_cnt  <= '0;
      ready_en <= 1'b0;
    end else begin
      state    <= state_nx;
      ready_en <= 1'b1;
      if (accept) begin
        i_par_q <= word.din;
        dir_q   <= word.dir;
      end
      case (state)
        S_LOAD: begin
          bit_cnt <= 2'd0;
          per_cnt <= '0;
        end
        S_HOLD:  per_cnt <= per_cnt + CNT_W'(1);
        S_SHIFT: begin
          if (bit_cnt != 2'd3) bit_cnt <= bit_cnt + 2'd1;
          per_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_nx   = state;
    mode       = 2'b00;
    I_par      = i_par_q;
    busy       = 1'b0;
    done       = 1'b0;
    bit_strobe = 1'b0;
`ifdef SHIFT_REG_4_CTRL_ABORT_EN
    aborted    = 1'b0;
`endif

    case (state)
      S_IDLE: begin
        if (accept) state_nx = S_LOAD;
      end
      S_LOAD: begin
        mode     = 2'b11;
        busy     = 1'b1;
        state_nx = DIV1 ? S_SHIFT : S_HOLD;
      end
      S_HOLD: begin
        busy       = 1'b1;
        bit_strobe = (per_cnt == '0);
        if (per_cnt == PER_LAST) state_nx = S_SHIFT;
      end
      S_SHIFT: begin
        busy       = 1'b1;
        mode       = dir_q ? 2'b10 : 2'b01;
        bit_strobe = DIV1;
        if (bit_cnt == 2'd3) state_nx = S_DONE;
        else                 state_nx = DIV1 ? S_SHIFT : S_HOLD;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
`ifdef SHIFT_REG_4_CTRL_ABORT_EN
      S_ABORT: begin
        // Reload all ones so the register, and hence the line, returns idle-high.
        mode     = 2'b11;
        I_par    = 4'hF;
        aborted  = 1'b1;
        state_nx = S_IDLE;
      end
`endif
      default: state_nx = S_IDLE;
    endcase

`ifdef SHIFT_REG_4_CTRL_ABORT_EN
    if (abort && (state == S_LOAD || state == S_HOLD || state == S_SHIFT))
      state_nx = S_ABORT;
`endif
  end

endmodule

// File: tb/tb_shift_reg_4_ctrl.sv
// Bench for shift_reg_4_ctrl: two instances (BIT_DIV=4 and BIT_DIV=1) driving behavioural
// 4-bit universal shift registers; expectations come from the serializer's timing rules.
module tb_shift_reg_4_ctrl;

  logic CLK;
  logic Clear_b;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  shift_reg_4_ctrl_if if_a ();
  shift_reg_4_ctrl_if if_b ();

  logic [3:0] a_par_a, a_par_b, i_par_a, i_par_b, reg_a, reg_b;
  logic s1_a, s0_a, msb_a, lsb_a, ser_a, stb_a, busy_a, done_a;
  logic s1_b, s0_b, msb_b, lsb_b, ser_b, stb_b, busy_b, done_b;
  logic abort_a, abort_b, aborted_a, aborted_b;

  shift_reg_4_ctrl #(.BIT_DIV(4), .CNT_W(8)) dut_a (
    .CLK(CLK), .Clear_b(Clear_b), .word(if_a.slave), .A_par(a_par_a),
    .s1(s1_a), .s0(s0_a), .I_par(i_par_a), .MSB_in(msb_a), .LSB_in(lsb_a),
    .ser_out(ser_a), .bit_strobe(stb_a), .busy(busy_a), .done(done_a)
`ifdef SHIFT_REG_4_CTRL_ABORT_EN
    , .abort(abort_a), .aborted(aborted_a)
`endif
  );

  shift_reg_4_ctrl #(.BIT_DIV(1), .CNT_W(8)) dut_b (
    .CLK(CLK), .Clear_b(Clear_b), .word(if_b.slave), .A_par(a_par_b),
    .s1(s1_b), .s0(s0_b), .I_par(i_par_b), .MSB_in(msb_b), .LSB_in(lsb_b),
    .ser_out(ser_b), .bit_strobe(stb_b), .busy(busy_b), .done(done_b)
`ifdef SHIFT_REG_4_CTRL_ABORT_EN
    , .abort(abort_b), .aborted(aborted_b)
`endif
  );

`ifndef SHIFT_REG_4_CTRL_ABORT_EN
  assign aborted_a = 1'b0;
  assign aborted_b = 1'b0;
`endif

  // Universal shift register models: 00 hold, 01 right, 10 left, 11 load.
  always @(posedge CLK) begin
    if (!Clear_b) reg_a <= 4'h0;
    else case ({s1_a, s0_a})
      2'b01:   reg_a <= {msb_a, reg_a[3:1]};
      2'b10:   reg_a <= {reg_a[2:0], lsb_a};
      2'b11:   reg_a <= i_par_a;
      default: reg_a <= reg_a;
    endcase
  end

  always @(posedge CLK) begin
    if (!Clear_b) reg_b <= 4'h0;
    else case ({s1_b, s0_b})
      2'b01:   reg_b <= {msb_b, reg_b[3:1]};
      2'b10:   reg_b <= {reg_b[2:0], lsb_b};
      2'b11:   reg_b <= i_par_b;
      default: reg_b <= reg_b;
    endcase
  end

  assign a_par_a = reg_a;
  assign a_par_b = reg_b;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [1:0] g_ss(input int sel);
    return (sel != 0) ? {s1_b, s0_b} : {s1_a, s0_a};
  endfunction
  function automatic logic g_ser(input int sel);
    return (sel != 0) ? ser_b : ser_a;
  endfunction
  function automatic logic g_stb(input int sel);
    return (sel != 0) ? stb_b : stb_a;
  endfunction
  function automatic logic g_busy(input int sel);
    return (sel != 0) ? busy_b : busy_a;
  endfunction
  function automatic logic g_done(input int sel);
    return (sel != 0) ? done_b : done_a;
  endfunction
  function automatic logic g_rdy(input int sel);
    return (sel != 0) ? if_b.din_ready : if_a.din_ready;
  endfunction
  function automatic logic [3:0] g_ipar(input int sel);
    return (sel != 0) ? i_par_b : i_par_a;
  endfunction
  function automatic logic [3:0] g_reg(input int sel);
    return (sel != 0) ? reg_b : reg_a;
  endfunction

  task automatic set_in(input int sel, input logic [3:0] w, input logic d, input logic v);
    if (sel != 0) begin
      if_b.din = w; if_b.dir = d; if_b.din_valid = v;
    end else begin
      if_a.din = w; if_a.dir = d; if_a.din_valid = v;
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Offers one word and checks every cycle from LOAD (cycle 1) to the done cycle against
  // the timing rules: bit k occupies cycles 2+k*BD .. 1+(k+1)*BD, done at 2+4*BD.
  // Returns with time positioned in the done cycle.
  task automatic run_word(input int sel, input logic [3:0] w, input logic d,
                          input bit hold, input logic [3:0] next_w, output int waited);
    int bd, last, k, j;
    logic [1:0] e_ss;
    logic e_busy, e_done, e_stb, e_ser, chk_ser;
    bd   = (sel != 0) ? 1 : 4;
    last = 2 + 4 * bd;
    set_in(sel, w, d, 1'b1);
    waited = 0;
    while (g_rdy(sel) !== 1'b1 && waited < 50) begin
      tick();
      waited++;
    end
    total_cnt++;
    if (g_rdy(sel) !== 1'b1)
      $display("FAIL accept_timeout[%0d]: din_ready=%b after %0d cycles, want 1", sel, g_rdy(sel), waited);
    else pass_cnt++;
    tick();
    if (hold) set_in(sel, next_w, ~d, 1'b1);
    else      set_in(sel, 4'($urandom), ~d, 1'b0);
    for (int c = 1; c <= last; c++) begin
      e_ss = 2'b00; e_busy = 1'b0; e_done = 1'b0; e_stb = 1'b0; e_ser = 1'b1; chk_ser = 1'b1;
      if (c == 1) begin
        e_ss = 2'b11; e_busy = 1'b1; chk_ser = 1'b0;
        total_cnt++;
        if (g_ipar(sel) !== w)
          $display("FAIL i_par[%0d]: got %b want %b", sel, g_ipar(sel), w);
        else pass_cnt++;
      end else if (c == last) begin
        e_done = 1'b1;
      end else begin
        k      = (c - 2) / bd;
        j      = (c - 2) % bd;
        e_busy = 1'b1;
        e_stb  = (j == 0);
        e_ss   = (j == bd - 1) ? (d ? 2'b10 : 2'b01) : 2'b00;
        e_ser  = d ? w[3 - k] : w[k];
      end
      total_cnt++;
      if (g_ss(sel) !== e_ss)
        $display("FAIL s1s0[%0d] w=%b d=%b c=%0d: got %b want %b", sel, w, d, c, g_ss(sel), e_ss);
      else pass_cnt++;
      total_cnt++;
      if (g_busy(sel) !== e_busy)
        $display("FAIL busy[%0d] w=%b c=%0d: got %b want %b", sel, w, c, g_busy(sel), e_busy);
      else pass_cnt++;
      total_cnt++;
      if (g_done(sel) !== e_done)
        $display("FAIL done[%0d] w=%b c=%0d: got %b want %b", sel, w, c, g_done(sel), e_done);
      else pass_cnt++;
      total_cnt++;
      if (g_stb(sel) !== e_stb)
        $display("FAIL bit_strobe[%0d] w=%b c=%0d: got %b want %b", sel, w, c, g_stb(sel), e_stb);
      else pass_cnt++;
      total_cnt++;
      if (g_rdy(sel) !== 1'b0)
        $display("FAIL din_ready_busy[%0d] c=%0d: got %b want 0", sel, c, g_rdy(sel));
      else pass_cnt++;
      if (chk_ser) begin
        total_cnt++;
        if (g_ser(sel) !== e_ser)
          $display("FAIL ser_out[%0d] w=%b d=%b c=%0d: got %b want %b", sel, w, d, c, g_ser(sel), e_ser);
        else pass_cnt++;
      end
      if (c != last) tick();
    end
    total_cnt++;
    if (g_reg(sel) !== 4'hF)
      $display("FAIL final_reg[%0d] w=%b d=%b: got %b want 1111", sel, w, d, g_reg(sel));
    else pass_cnt++;
  endtask

  task automatic check_idle(input int sel);
    total_cnt++;
    if (g_rdy(sel) !== 1'b1 || g_ser(sel) !== 1'b1 || g_busy(sel) !== 1'b0 || g_ss(sel) !== 2'b00)
      $display("FAIL idle[%0d]: got rdy=%b ser=%b busy=%b s1s0=%b want 1 1 0 00",
               sel, g_rdy(sel), g_ser(sel), g_busy(sel), g_ss(sel));
    else pass_cnt++;
  endtask

  task automatic test_reset();
    int seen_done;
    set_in(0, 4'b1001, 1'b0, 1'b1);
    tick();
    set_in(0, 4'b0000, 1'b0, 1'b0);
    repeat (6) tick();
    Clear_b = 1'b0;
    tick();
    total_cnt++;
    if (g_ss(0) !== 2'b00 || busy_a !== 1'b0 || ser_a !== 1'b1 || done_a !== 1'b0 || stb_a !== 1'b0)
      $display("FAIL reset_outputs: got s1s0=%b busy=%b ser=%b done=%b stb=%b want 00 0 1 0 0",
               g_ss(0), busy_a, ser_a, done_a, stb_a);
    else pass_cnt++;
    total_cnt++;
    if (i_par_a !== 4'h0)
      $display("FAIL reset_i_par: got %b want 0000", i_par_a);
    else pass_cnt++;
    total_cnt++;
    if (msb_a !== 1'b1 || lsb_a !== 1'b1)
      $display("FAIL fill_bits: got msb=%b lsb=%b want 1 1", msb_a, lsb_a);
    else pass_cnt++;
    seen_done = 0;
    repeat (2) begin
      tick();
      if (done_a === 1'b1 || busy_a !== 1'b0) seen_done++;
    end
    total_cnt++;
    if (seen_done != 0)
      $display("FAIL reset_hold: got %0d cycles with done/busy active want 0", seen_done);
    else pass_cnt++;
    Clear_b = 1'b1;
    tick();
    total_cnt++;
    if (if_a.din_ready !== 1'b1 || g_ss(0) !== 2'b00 || reg_a !== 4'h0)
      $display("FAIL reset_release: got rdy=%b s1s0=%b reg=%b want 1 00 0000",
               if_a.din_ready, g_ss(0), reg_a);
    else pass_cnt++;
    repeat (3) begin
      tick();
      total_cnt++;
      if (done_a !== 1'b0)
        $display("FAIL reset_no_done: got done=%b want 0", done_a);
      else pass_cnt++;
    end
  endtask

  task automatic test_lsb_first();
    int waited;
    run_word(0, 4'b1011, 1'b0, 1'b0, 4'b0000, waited);
    tick();
    check_idle(0);
  endtask

  task automatic test_msb_first();
    int waited;
    run_word(0, 4'b1011, 1'b1, 1'b0, 4'b0000, waited);
    tick();
    check_idle(0);
  endtask

  task automatic test_bit_div_1();
    int waited;
    run_word(1, 4'b0110, 1'b0, 1'b0, 4'b0000, waited);
    tick();
    check_idle(1);
    run_word(1, 4'b0011, 1'b1, 1'b0, 4'b0000, waited);
    tick();
    check_idle(1);
  endtask

  task automatic test_back_to_back();
    int waited;
    run_word(0, 4'b0101, 1'b0, 1'b1, 4'b1100, waited);
    run_word(0, 4'b1100, 1'b1, 1'b0, 4'b0000, waited);
    total_cnt++;
    if (waited != 1)
      $display("FAIL b2b_gap: got second accept %0d cycles after done want 1", waited);
    else pass_cnt++;
    tick();
    check_idle(0);
  endtask

  task automatic test_random();
    int waited, sel, gap;
    logic [3:0] w;
    logic d;
    for (int i = 0; i < 16; i++) begin
      sel = i % 2;
      w   = 4'($urandom);
      d   = 1'($urandom);
      run_word(sel, w, d, 1'b0, 4'b0000, waited);
      tick();
      check_idle(sel);
      gap = $urandom_range(0, 3);
      repeat (gap) tick();
    end
  endtask

`ifdef SHIFT_REG_4_CTRL_ABORT_EN
  task automatic test_abort();
    int bad;
    abort_a = 1'b1;
    tick();
    total_cnt++;
    if (aborted_a !== 1'b0 || if_a.din_ready !== 1'b1)
      $display("FAIL abort_in_idle: got aborted=%b rdy=%b want 0 1", aborted_a, if_a.din_ready);
    else pass_cnt++;
    abort_a = 1'b0;
    set_in(0, 4'b1011, 1'b0, 1'b1);
    tick();
    set_in(0, 4'b0000, 1'b0, 1'b0);
    repeat (10) tick();
    total_cnt++;
    if (ser_a !== 1'b0 || busy_a !== 1'b1)
      $display("FAIL abort_bit2: got ser=%b busy=%b want 0 1", ser_a, busy_a);
    else pass_cnt++;
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    total_cnt++;
    if (g_ss(0) !== 2'b11 || i_par_a !== 4'hF || aborted_a !== 1'b1 || done_a !== 1'b0 || ser_a !== 1'b1)
      $display("FAIL abort_state: got s1s0=%b i_par=%b aborted=%b done=%b ser=%b want 11 1111 1 0 1",
               g_ss(0), i_par_a, aborted_a, done_a, ser_a);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (if_a.din_ready !== 1'b1 || aborted_a !== 1'b0 || done_a !== 1'b0 || reg_a !== 4'hF)
      $display("FAIL abort_exit: got rdy=%b aborted=%b done=%b reg=%b want 1 0 0 1111",
               if_a.din_ready, aborted_a, done_a, reg_a);
    else pass_cnt++;
    bad = 0;
    repeat (8) begin
      tick();
      if (done_a !== 1'b0) bad++;
    end
    total_cnt++;
    if (bad != 0)
      $display("FAIL abort_no_done: got %0d done pulses want 0", bad);
    else pass_cnt++;
  endtask
`endif

  initial begin
    abort_a = 1'b0;
    abort_b = 1'b0;
    set_in(0, 4'h0, 1'b0, 1'b0);
    set_in(1, 4'h0, 1'b0, 1'b0);
    Clear_b = 1'b0;
    repeat (2) tick();
    Clear_b = 1'b1;
    tick();
    check_idle(0);
    check_idle(1);
    test_reset();
    test_lsb_first();
    test_msb_first();
    test_bit_div_1();
    test_back_to_back();
    test_random();
`ifdef SHIFT_REG_4_CTRL_ABORT_EN
    test_abort();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
